// File: rtl/mult_div_if.sv
// Operand/start/result bundle between the CPU datapath and the signed multiply/divide unit.
// The CPU side drives start and operands; the unit returns HI/LO and status.
interface mult_div_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start_mult, start_div, a, b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring on magnitudes).
// One bit per cycle, results land in HI/LO on the edge entering DONE.
module mult_div (
  input  logic         clk,
  input  logic         reset,
  mult_div_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Booth step on {A, Q, q-1}; A is widened to 33 bits so A - (-2^31) cannot overflow.
  function automatic logic [64:0] booth_step(input logic [64:0] acc, input logic [31:0] m);
    logic [32:0] ax;
    logic [32:0] mx;
    logic [32:0] sum;
    ax = {acc[64], acc[64:33]};
    mx = {m[31], m};
    case (acc[1:0])
      2'b01:   sum = ax + mx;
      2'b10:   sum = ax - mx;
      default: sum = ax;
    endcase
    return {sum, acc[32:1]};
  endfunction

  // Restoring step on {remainder, dividend/quotient}; divisor magnitude is at most 2^31.
  function automatic logic [63:0] div_step(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] sh;
    logic [33:0] diff;
    sh   = {rq[63:32], rq[31]};
    diff = {1'b0, sh} - {2'b00, d};
    if (diff[33]) begin
      return {sh[31:0], rq[30:0], 1'b0};
    end else begin
      return {diff[31:0], rq[30:0], 1'b1};
    end
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    if (x[31]) begin
      return 32'd0 - x;
    end else begin
      return x;
    end
  endfunction

  state_t      state_r;
  logic [5:0]  count_r;
  logic [64:0] acc_r;
  logic [63:0] rq_r;
  logic [31:0] opnd_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic [64:0] mult_nxt_s;
  logic [63:0] div_nxt_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // Next iteration values and the signed fix-up applied on the final divide step.
  always_comb begin
    mult_nxt_s = booth_step(acc_r, opnd_r);
    div_nxt_s  = div_step(rq_r, opnd_r);
    quo_fix_s  = div_nxt_s[31:0];
    rem_fix_s  = div_nxt_s[63:32];
    if (neg_q_r) begin
      quo_fix_s = 32'd0 - div_nxt_s[31:0];
    end else begin
      quo_fix_s = div_nxt_s[31:0];
    end
    if (neg_r_r) begin
      rem_fix_s = 32'd0 - div_nxt_s[63:32];
    end else begin
      rem_fix_s = div_nxt_s[63:32];
    end
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      count_r    <= 6'd0;
      acc_r      <= 65'd0;
      rq_r       <= 64'd0;
      opnd_r     <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_mult) begin
            acc_r   <= {32'd0, bus.b, 1'b0};
            opnd_r  <= bus.a;
            count_r <= 6'd0;
            busy_r  <= 1'b1;
            state_r <= MULT;
          end else if (bus.start_div) begin
            if (bus.b != 32'd0) begin
              rq_r    <= {32'd0, abs32(bus.a)};
              opnd_r  <= abs32(bus.b);
              neg_q_r <= bus.a[31] ^ bus.b[31];
              neg_r_r <= bus.a[31];
              count_r <= 6'd0;
              busy_r  <= 1'b1;
              state_r <= DIV;
            end else begin
              done_r     <= 1'b1;
              div_zero_r <= 1'b1;
              state_r    <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MULT: begin
          acc_r <= mult_nxt_s;
          if (count_r == 6'd31) begin
            hi_r    <= mult_nxt_s[64:33];
            lo_r    <= mult_nxt_s[32:1];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            count_r <= count_r + 6'd1;
          end
        end
        DIV: begin
          rq_r <= div_nxt_s;
          if (count_r == 6'd31) begin
            hi_r    <= rem_fix_s;
            lo_r    <= quo_fix_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            count_r <= count_r + 6'd1;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi_out   = hi_r;
  assign bus.lo_out   = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed vector table, random ops against an
// arithmetic reference model, and a mid-divide asynchronous reset sequence.
module tb_mult_div;

  logic clk;
  logic reset;
  mult_div_if bus ();

  mult_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  typedef struct {
    string       name;
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; issues one start and follows the operation to completion.
  task automatic run_op(input string nm, input logic sm, input logic sd,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat);
    int   cyc;
    logic busy_ok;
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.a          = av;
    bus.b          = bv;
    @(posedge clk); #1;
    cyc     = 1;
    busy_ok = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      bus.a          = $urandom;
      bus.b          = $urandom;
      bus.start_mult = 1'($urandom_range(0, 1));
      bus.start_div  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    check({nm, " latency"}, 64'(cyc), 64'(elat));
    check({nm, " busy during op"}, 64'(busy_ok), 64'd1);
    check({nm, " hi"}, 64'(bus.hi_out), 64'(ehi));
    check({nm, " lo"}, 64'(bus.lo_out), 64'(elo));
    check({nm, " div_zero"}, 64'(bus.div_zero), 64'(edz));
    check({nm, " busy at done"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check({nm, " done one cycle"}, 64'({bus.done, bus.div_zero, bus.busy}), 64'd0);
    @(posedge clk); #1;
    check({nm, " no queued start"}, 64'(bus.busy), 64'd0);
    model_hi = ehi;
    model_lo = elo;
  endtask

  vec_t vecs[9];

  initial begin
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    logic        do_mult;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          elat;
    logic        quiet;

    vecs[0] = '{"mul 7x-3",        1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1] = '{"mul min x min",   1'b1, 1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2] = '{"div -7/2",        1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3] = '{"div min/-1",      1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4] = '{"both 6,4",        1'b1, 1'b1, 32'd6,          32'd4,        32'h00000000, 32'h00000018, 1'b0, 33};
    vecs[5] = '{"div 5/0",         1'b0, 1'b1, 32'd5,          32'd0,        32'h00000000, 32'h00000018, 1'b1, 1};
    vecs[6] = '{"mul -1x-1",       1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[7] = '{"div 7/-2",        1'b0, 1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[8] = '{"div 100/7",       1'b0, 1'b1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33};

    reset          = 1'b0;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    #2;
    check("reset outputs", {bus.hi_out, bus.lo_out}, 64'd0);
    check("reset status", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
    #10;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sm, vecs[i].sd, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
    end

    for (int k = 0; k < 24; k++) begin
      do_mult = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (k % 5 == 1) rb = 32'(-$signed(32'($urandom_range(1, 9))));
      if (do_mult) begin
        p    = 64'(longint'($signed(ra)) * longint'($signed(rb)));
        ehi  = p[63:32];
        elo  = p[31:0];
        edz  = 1'b0;
        elat = 33;
      end else if (rb == 32'd0) begin
        ehi  = model_hi;
        elo  = model_lo;
        edz  = 1'b1;
        elat = 1;
      end else begin
        q    = 64'(longint'($signed(ra)) / longint'($signed(rb)));
        r    = 64'(longint'($signed(ra)) % longint'($signed(rb)));
        ehi  = r[31:0];
        elo  = q[31:0];
        edz  = 1'b0;
        elat = 33;
      end
      run_op(do_mult ? "rand mul" : "rand div", do_mult, ~do_mult, ra, rb, ehi, elo, edz, elat);
    end

    // Abort a divide with reset in its tenth cycle.
    bus.start_div = 1'b1;
    bus.a         = 32'd1000;
    bus.b         = 32'd7;
    @(posedge clk); #1;
    bus.start_div = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("busy before abort", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort hi/lo zero", {bus.hi_out, bus.lo_out}, 64'd0);
    check("abort status zero", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    check("no done after abort", 64'(quiet), 64'd1);
    model_hi = 32'd0;
    model_lo = 32'd0;
    run_op("mul 3x5 after reset", 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
